id_branch_hazard_ctrl: RTL and testbench
========================================

// Module: id_branch_hazard_ctrl
// PURPOSE
// - Consumer end of the instruction-fetch interface: owns the IF/ID pipeline register, decodes branch/jump in ID,
//   resolves them, and drives stall, is_branch and pc_final back to the fetch stage.
// - Detects load-use and branch-operand hazards against the EX and MEM stages; inserts bubbles and flushes wrong-path fetches.
// PARAMETERS
// - PC_WRAP   36  fetch PC range in bytes; pc_final values >= PC_WRAP are driven as 0.
// - CNT_W     16  width of the saturating performance counters.
// PORTS
// - clk            in   1      clock; all state updates on posedge
// - reset          in   1      synchronous, active-high
// - if_instr       in   32     instruction word from the fetch stage
// - if_pc          in   32     PC of if_instr
// - rs_data        in   32     register-file read data for id_rs, combinational
// - rt_data        in   32     register-file read data for id_rt, combinational
// - ex_reg_write   in   1      instruction in EX writes a register
// - ex_mem_read    in   1      instruction in EX is lw
// - ex_dest        in   5      EX destination register
// - mem_mem_read   in   1      instruction in MEM is lw
// - mem_dest       in   5      MEM destination register
// - stall          out  1      fetch holds PC; IF/ID holds
// - is_branch      out  1      redirect fetch to pc_final at the next edge
// - pc_final       out  32     redirect target
// - id_instr       out  32     IF/ID instruction; NOP 0x00000000 when invalid
// - id_pc          out  32     IF/ID PC
// - id_valid       out  1      ID instruction is real; 0 means a bubble goes to ID/EX
// - id_rs, id_rt   out  5      id_instr[25:21] and id_instr[20:16]
// - stall_cnt      out  CNT_W  stall cycles, saturating
// - redirect_cnt   out  CNT_W  taken redirects, saturating
// BEHAVIOUR
// - Reset: IF/ID = {NOP, pc 0, valid 0}; state = RUN; both counters = 0.
//   stall, is_branch and pc_final are all 0 while reset is high and in the first cycle after reset.
// - Decode (opcode id_instr[31:26]):
//   - beq 0x04, bne 0x05: taken when rs_data ==/!= rt_data; target = id_pc + 4 + (sext(imm16) << 2), 32-bit wrap.
//   - j 0x02: always taken; target = {id_pc+4 [31:28], addr26, 2'b00}.
//   - Uses rs: every opcode except j. Uses rt: R-type (0x00), beq, bne, sw (0x2B).
// - Hazard (combinational; evaluated only when id_valid = 1; register 0 never matches):
//   - Load-use: ex_mem_read and ex_dest equals a used rs/rt.
//   - Branch-in-EX: id is beq/bne, ex_reg_write, ex_dest equals rs or rt.
//   - Branch-in-MEM: id is beq/bne, mem_mem_read, mem_dest equals rs or rt.
//   - stall = OR of the three terms. Result: branch after ALU op = 1 bubble; branch after lw = 2 bubbles.
// - State machine:
//   - RUN: normal operation.
//   - STALL: entered while stall = 1. IF/ID holds; the downstream bubble is signalled by forcing id_valid_out = 0.
//   - FLUSH: the single cycle after a taken redirect.
//   - Transitions: RUN->STALL when stall; STALL->RUN when !stall; RUN/STALL->FLUSH when is_branch; FLUSH->RUN always.
// - Redirect: is_branch = id_valid & taken & !stall. pc_final = target, or 0 if target >= PC_WRAP.
//   - At the same edge, IF/ID loads {NOP, if_pc, valid 0}; the wrong-path fetch is squashed.
//   - So the cycle after a redirect always presents a bubble in ID.
// - Normal edge: IF/ID <= {if_instr, if_pc, 1} when !stall & !is_branch.
// - Priority: reset > stall > is_branch > normal load. Stall and taken branch in the same cycle: stall wins,
//   is_branch = 0, and the branch re-resolves on a later cycle with fresh operands.
// - Counters: stall_cnt +1 each cycle stall = 1; redirect_cnt +1 each cycle is_branch = 1.
//   Both hold at 2^CNT_W-1 (saturate, never wrap).
// - Reset mid-stall or mid-flush: synchronous return to the reset state at the next edge; no pending redirect survives.
// STRUCTURE
// - Shared package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW), NOP word,
//   id_state_t enum {RUN, STALL, FLUSH}.
// - One sub-module: branch_resolve (combinational comparator plus target adder); hazard logic, FSM and IF/ID register stay here.
// TESTING
// - Reset held 3 cycles, then released -> stall=0, is_branch=0, id_valid=0, counters 0;
//   next edge loads if_instr with id_valid=1.
// - id beq $1,$2,+2 at id_pc 8, rs_data = rt_data = 5 -> is_branch=1, pc_final=20;
//   next cycle id_instr=NOP, id_valid=0; redirect_cnt=1.
// - id add $3,$4,$5 with ex_mem_read=1, ex_dest=4 -> stall=1 for exactly 1 cycle; IF/ID unchanged; id_valid_out=0; stall_cnt=1.
// - id bne $6,$0 with lw $6 in EX, moving to MEM next cycle -> stall for 2 cycles, then resolve;
//   rs_data=7 -> is_branch=1.
// - id j with target 40 at id_pc 0 -> pc_final=0 (40 >= PC_WRAP), is_branch=1.
// - Stall asserted on a taken beq, then reset pulsed for 1 cycle -> no redirect issued; all outputs are at reset values after the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, NOP word and ID-stage state type shared by the ID stage
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} id_state_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: beq/bne/j outcome and redirect target for the instruction in ID
module branch_resolve
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        taken,
  output logic [31:0] target
);
  logic [5:0]  op;
  logic [31:0] pc4;
  // compare operands and form either the pc-relative or the region-absolute target
  always_comb begin
    op = instr[31:26];
    pc4 = pc + 32'd4;
    taken = op == OP_BEQ ? rs_data == rt_data : op == OP_BNE ? rs_data != rt_data : op == OP_J;
    target = op == OP_J ? {pc4[31:28], instr[25:0], 2'b00} : pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end
endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// id_branch_hazard_ctrl: IF/ID register, branch resolution in ID, hazard stalls and fetch redirect
module id_branch_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int PC_WRAP = 36,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_dest,
  output logic             stall,
  output logic             is_branch,
  output logic [31:0]      pc_final,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);
  logic [31:0] instr_r, pc_r, target;
  logic        valid_r, v, taken, use_rs, use_rt, br_op;
  logic        ex_rs, ex_rt, mem_rs, mem_rt, load_use, br_ex, br_mem;
  logic [5:0]  op;
  id_state_t   state;

  branch_resolve u_branch_resolve (
    .instr   (instr_r),
    .pc      (pc_r),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .taken   (taken),
    .target  (target)
  );

  assign id_instr = instr_r;
  assign id_pc    = pc_r;
  assign id_rs    = instr_r[25:21];
  assign id_rt    = instr_r[20:16];
  assign id_valid = v & ~stall;

  // operand use decode, hazard detection against EX/MEM, and redirect request
  always_comb begin
    op = instr_r[31:26];
    v = valid_r & ~reset;
    use_rs = op != OP_J;
    use_rt = op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
    br_op = op == OP_BEQ || op == OP_BNE;
    ex_rs = ex_dest != 5'd0 && ex_dest == id_rs;
    ex_rt = ex_dest != 5'd0 && ex_dest == id_rt;
    mem_rs = mem_dest != 5'd0 && mem_dest == id_rs;
    mem_rt = mem_dest != 5'd0 && mem_dest == id_rt;
    load_use = ex_mem_read & ((use_rs & ex_rs) | (use_rt & ex_rt));
    br_ex = br_op & ex_reg_write & (ex_rs | ex_rt);
    br_mem = br_op & mem_mem_read & (mem_rs | mem_rt);
    stall = v & (load_use | br_ex | br_mem);
    is_branch = v & taken & ~stall;
    pc_final = is_branch && target < 32'(PC_WRAP) ? target : 32'd0;
  end

  // IF/ID register: hold while stalled, squash the wrong-path fetch on redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= NOP;
      pc_r <= 32'd0;
      valid_r <= 1'b0;
    end else if (!stall) begin
      instr_r <= is_branch ? NOP : if_instr;
      pc_r <= if_pc;
      valid_r <= ~is_branch;
    end
  end

  // ID stage state: a flush lasts one cycle, stalls persist while the hazard does
  always_ff @(posedge clk)
    state <= reset || state == FLUSH ? RUN : is_branch ? FLUSH : stall ? STALL : RUN;

  // saturating stall and redirect counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (is_branch && redirect_cnt != '1) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// tb_id_branch_hazard_ctrl: directed scenarios plus random traffic against a spec-level model
module tb_id_branch_hazard_ctrl;
  localparam int CW = 4;
  localparam int WRAP = 36;

  logic          clk = 0;
  logic          reset;
  logic [31:0]   if_instr, if_pc, rs_data, rt_data;
  logic          ex_reg_write, ex_mem_read, mem_mem_read;
  logic [4:0]    ex_dest, mem_dest;
  logic          stall, is_branch, id_valid;
  logic [31:0]   pc_final, id_instr, id_pc;
  logic [4:0]    id_rs, id_rt;
  logic [CW-1:0] stall_cnt, redirect_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  int          m_sc, m_rc;

  always #5 clk = ~clk;

  id_branch_hazard_ctrl #(.PC_WRAP(WRAP), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dest      (ex_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .stall        (stall),
    .is_branch    (is_branch),
    .pc_final     (pc_final),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  // model: what the ID stage must show this cycle, then what IF/ID holds after the edge
  task automatic tick();
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [4:0]  used[$];
    logic [31:0] t;
    bit          v, lu, bx, bm, tk, st, br;
    int          off, sat;
    #1;
    sat = (1 << CW) - 1;
    op = m_instr[31:26];
    rs = m_instr[25:21];
    rt = m_instr[20:16];
    v = m_valid && !reset;
    if (op != 6'h02) used.push_back(rs);
    if (op inside {6'h00, 6'h04, 6'h05, 6'h2B}) used.push_back(rt);
    lu = 0;
    foreach (used[i]) if (ex_mem_read && used[i] != 0 && used[i] == ex_dest) lu = 1;
    bx = (op inside {6'h04, 6'h05}) && ex_reg_write && ex_dest != 0 && (ex_dest == rs || ex_dest == rt);
    bm = (op inside {6'h04, 6'h05}) && mem_mem_read && mem_dest != 0 && (mem_dest == rs || mem_dest == rt);
    st = v && (lu || bx || bm);
    if (op == 6'h04) tk = rs_data == rt_data;
    else if (op == 6'h05) tk = rs_data != rt_data;
    else tk = op == 6'h02;
    br = v && tk && !st;
    off = int'($signed(m_instr[15:0]));
    if (op == 6'h02) t = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
    else t = m_pc + 32'd4 + 32'(off * 4);
    check("stall", {31'd0, stall}, {31'd0, st});
    check("is_branch", {31'd0, is_branch}, {31'd0, br});
    check("pc_final", pc_final, (br && t < WRAP) ? t : 32'd0);
    check("id_instr", id_instr, m_instr);
    check("id_pc", id_pc, m_pc);
    check("id_valid", {31'd0, id_valid}, {31'd0, v && !st});
    check("id_rs", {27'd0, id_rs}, {27'd0, rs});
    check("id_rt", {27'd0, id_rt}, {27'd0, rt});
    check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_rc));
    if (reset) begin
      m_instr = 0; m_pc = 0; m_valid = 0; m_sc = 0; m_rc = 0;
    end else if (st) begin
      if (m_sc < sat) m_sc++;
    end else if (br) begin
      m_instr = 0; m_pc = if_pc; m_valid = 0;
      if (m_rc < sat) m_rc++;
    end else begin
      m_instr = if_instr; m_pc = if_pc; m_valid = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ex_reg_write = 0; ex_mem_read = 0; ex_dest = 0;
    mem_mem_read = 0; mem_dest = 0; rs_data = 0; rt_data = 0;
  endtask

  initial begin
    logic [5:0] op;
    reset = 1;
    if_instr = 0; if_pc = 0;
    quiet();
    @(posedge clk);
    #1;
    m_instr = 0; m_pc = 0; m_valid = 0; m_sc = 0; m_rc = 0;
    tick();
    tick();
    reset = 0;
    if_instr = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    if_pc = 32'd8;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_is_branch", {31'd0, is_branch}, 32'd0);
    check("rst_pc_final", pc_final, 32'd0);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    tick();
    check("load_valid", {31'd0, id_valid}, 32'd1);
    check("load_instr", id_instr, enc_i(6'h04, 5'd1, 5'd2, 16'd2));
    rs_data = 5; rt_data = 5;
    if_instr = 32'h1234_5678; if_pc = 32'd12;
    #1;
    check("beq_is_branch", {31'd0, is_branch}, 32'd1);
    check("beq_pc_final", pc_final, 32'd20);
    tick();
    check("beq_squash_instr", id_instr, 32'd0);
    check("beq_squash_valid", {31'd0, id_valid}, 32'd0);
    check("beq_redirect_cnt", 32'(redirect_cnt), 32'd1);
    quiet();
    if_instr = enc_r(5'd4, 5'd5, 5'd3); if_pc = 32'd16;
    tick();
    ex_mem_read = 1; ex_dest = 5'd4;
    if_instr = 32'hDEAD_BEEF; if_pc = 32'd20;
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("lu_hold_instr", id_instr, enc_r(5'd4, 5'd5, 5'd3));
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_mem_read = 0;
    if_instr = enc_i(6'h05, 5'd6, 5'd0, 16'd3); if_pc = 32'd24;
    #1;
    check("lu_stall_end", {31'd0, stall}, 32'd0);
    check("lu_valid_back", {31'd0, id_valid}, 32'd1);
    tick();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5'd6; rs_data = 7; rt_data = 0;
    #1;
    check("bne_stall_ex", {31'd0, stall}, 32'd1);
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; mem_mem_read = 1; mem_dest = 5'd6;
    #1;
    check("bne_stall_mem", {31'd0, stall}, 32'd1);
    tick();
    mem_mem_read = 0; mem_dest = 0;
    #1;
    check("bne_resolve_stall", {31'd0, stall}, 32'd0);
    check("bne_is_branch", {31'd0, is_branch}, 32'd1);
    check("bne_stall_cnt", 32'(stall_cnt), 32'd3);
    tick();
    quiet();
    if_instr = {6'h02, 26'd10}; if_pc = 32'd0;
    tick();
    #1;
    check("j_is_branch", {31'd0, is_branch}, 32'd1);
    check("j_pc_final_wrap", pc_final, 32'd0);
    tick();
    if_instr = enc_i(6'h04, 5'd1, 5'd2, 16'd2); if_pc = 32'd4;
    tick();
    rs_data = 5; rt_data = 5; ex_reg_write = 1; ex_dest = 5'd1;
    #1;
    check("sb_stall", {31'd0, stall}, 32'd1);
    check("sb_is_branch", {31'd0, is_branch}, 32'd0);
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("sb_rst_stall", {31'd0, stall}, 32'd0);
    check("sb_rst_is_branch", {31'd0, is_branch}, 32'd0);
    check("sb_rst_pc_final", pc_final, 32'd0);
    check("sb_rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("sb_rst_id_instr", id_instr, 32'd0);
    check("sb_rst_id_pc", id_pc, 32'd0);
    check("sb_rst_cnts", 32'(stall_cnt) | 32'(redirect_cnt), 32'd0);
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h02;
        2: op = 6'h04;
        3: op = 6'h05;
        4: op = 6'h23;
        5: op = 6'h2B;
        default: op = 6'($urandom);
      endcase
      if (op == 6'h02) if_instr = {op, 26'($urandom_range(0, 12))};
      else if_instr = enc_i(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            $urandom_range(0, 1) ? 16'($urandom_range(0, 6)) : 16'($urandom));
      if_pc = 32'($urandom_range(0, 15)) * 4;
      rs_data = 32'($urandom_range(0, 2));
      rt_data = 32'($urandom_range(0, 2));
      ex_reg_write = $urandom_range(0, 2) == 0;
      ex_mem_read = $urandom_range(0, 2) == 0;
      ex_dest = 5'($urandom_range(0, 7));
      mem_mem_read = $urandom_range(0, 2) == 0;
      mem_dest = 5'($urandom_range(0, 7));
      reset = $urandom_range(0, 59) == 0;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
